usb_cmd_decoder: RTL
====================

// Module: usb_cmd_decoder
// PURPOSE
//  Consumes host command words from usb_controller (receive_data/receive_data_en).
//  Frames them, checks them and applies them to a bank of camera parameter registers.
//  Returns read-back responses through a response FIFO that usb_controller drains
//  via fifo_parameter_en/parameter_data; a send_out pulse requests each upload.
//  Sits directly downstream (cmd path) and upstream (param path) of usb_controller.
// PARAMETERS
//  NREG     16     number of 16-bit parameter registers (addr 0..NREG-1)
//  RST_VAL  0      NREG*16-bit flat reset/default value, reg i = RST_VAL[16*i+:16]
//  TIMEOUT  1024   max usb_clk cycles between words of one frame before abort
//  SYNC     16'hEB90  frame sync word
// PORTS
//  usb_clk           in   1        clock, all logic rising edge
//  rst_n             in   1        synchronous reset, active low
//  receive_data      in   16       command word from usb_controller
//  receive_data_en   in   1        receive_data valid this cycle
//  fifo_parameter_en in   1        usb_controller pops one response word
//  parameter_data    out  16       response word, valid cycle after pop
//  send_out          out  1        1-cycle pulse: one 4-word response ready
//  reg_bus           out  NREG*16  current register values, flat
//  reg_wr            out  1        1-cycle pulse on any register update
//  reg_wr_addr       out  8        address of last update (8'hFF = restore-all)
//  err_cnt           out  16       rejected-frame count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n=0 at edge): regs=RST_VAL, FIFO empty, FSM IDLE, parameter_data=0,
//   send_out=0, reg_wr=0, reg_wr_addr=0, err_cnt=0. Reset mid-frame discards frame.
//  Frame = 4 words: W0=SYNC, W1={cmd[7:0],addr[7:0]}, W2=data, W3=chk=(W1+W2) mod 2^16.
//  FSM: IDLE -> (en & word==SYNC) HDR -> (en) DAT -> (en) CHK -> (en) EXEC -> IDLE.
//   IDLE ignores non-SYNC words. SYNC inside HDR/DAT/CHK is taken as data (no resync).
//   Gap counter resets on every en; reaching TIMEOUT in HDR/DAT/CHK -> IDLE, err_cnt+1.
//  EXEC (one cycle after W3 accepted), checks in order, first failure wins:
//   chk mismatch -> err; cmd not in {01,02,03} -> err; cmd 01/02 with addr>=NREG -> err.
//   cmd 8'h01 WRITE: reg[addr]<=data at EXEC edge; reg_wr=1 next cycle, reg_wr_addr=addr.
//   cmd 8'h02 READ: if FIFO free>=4, push SYNC,{02,addr},reg[addr],checksum on 4
//    consecutive cycles; send_out pulses the cycle after the 4th push; else err (no push).
//   cmd 8'h03 RESTORE: all regs<=RST_VAL; reg_wr=1, reg_wr_addr=8'hFF; data ignored.
//   Errors: err_cnt+1 (saturating); no register or FIFO change.
//  Words arriving while EXEC/push in progress are dropped; host spacing is >=6 cycles.
//  Response FIFO: depth 16 words, registered read: pop when non-empty updates
//   parameter_data next cycle; pop on empty ignored, parameter_data holds.
//   Push and pop same cycle both occur; count unchanged.
//  Same-cycle WRITE to reg k and reg_bus read: reg_bus shows old value that cycle.
// STRUCTURE
//  Shared package usb_cmd_pkg: SYNC, CMD_WRITE=8'h01, CMD_READ=8'h02,
//   CMD_RESTORE=8'h03, FSM state encoding, frame length 4.
//  Sub-module usb_resp_fifo (16x16 sync FIFO, count, registered read) instantiated once.
//  Top holds FSM, gap counter, checksum adder, register bank, err counter.
// TESTING
//  WRITE: EB90,0105,1234,1339 -> reg[5]=16'h1234, reg_wr pulse, reg_wr_addr=5, err_cnt=0.
//  READ: after above, EB90,0205,1234,1439 -> FIFO gets EB90,0205,1234,1439; send_out
//   1 pulse; 4 pops -> parameter_data sequence EB90,0205,1234,1439; 5th pop holds 1439.
//  Bad chk: EB90,0103,00AA,0000 -> reg[3] unchanged, err_cnt=1; addr 8'h10 (NREG=16) -> err_cnt=2.
//  Timeout: EB90,0101 then idle 1024 cycles -> err_cnt+1, FSM IDLE; next valid frame accepted.
//  FIFO full: 4 READs without pops fill 16 words; 5th READ -> err, no send_out, FIFO intact.
//  Reset mid-frame: EB90,0107, rst_n low 1 cycle, then 0000,0107 -> no write, regs=RST_VAL.

Source files
------------

// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB command decoder.
//   Frame sync word, command opcodes, frame length, FSM state encoding,
//   execute-decision encoding, response FIFO geometry and the frame checksum.
package usb_cmd_pkg;

    localparam logic [15:0] SYNC        = 16'hEB90;
    localparam logic [7:0]  CMD_WRITE   = 8'h01;
    localparam logic [7:0]  CMD_READ    = 8'h02;
    localparam logic [7:0]  CMD_RESTORE = 8'h03;
    localparam logic [7:0]  ADDR_ALL    = 8'hFF;   // reg_wr_addr for restore-all

    localparam int FRAME_LEN  = 4;                 // words per frame and per response
    localparam int RESP_DEPTH = 16;                // response FIFO depth in words
    localparam int RESP_CW    = $clog2(RESP_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DAT,
        ST_CHK,
        ST_EXEC,
        ST_PUSH
    } state_t;

    // Outcome of the EXEC cycle after all frame checks.
    typedef enum logic [1:0] {
        OP_ERR,
        OP_WRITE,
        OP_READ,
        OP_RESTORE
    } exec_op_t;

    // Frame checksum: 16-bit wrap-around sum of header and data words.
    function automatic logic [15:0] frame_chk(input logic [15:0] hdr, input logic [15:0] dat);
        return hdr + dat;
    endfunction

endpackage

// File: rtl/usb_resp_fifo.sv
// Response FIFO, 16-bit words, synchronous, registered read port.
//   clk, rst_n : clock / synchronous active-low reset
//   push, wdata: write one word (ignored when full unless a pop frees a slot)
//   pop        : read one word; rdata updates the following cycle.
//                A pop on an empty FIFO is ignored and rdata holds.
//   rdata      : registered read data (0 after reset)
//   count      : number of words stored
module usb_resp_fifo
    import usb_cmd_pkg::*;
#(
    parameter int DEPTH = RESP_DEPTH,
    parameter int CW    = RESP_CW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   wdata,
    input  logic          pop,
    output logic [15:0]   rdata,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO may proceed.
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usb_cmd_decoder.sv
// USB host command decoder.
//   Frames 4-word host commands (SYNC, {cmd,addr}, data, checksum), validates
//   them and applies WRITE / READ / RESTORE to a bank of 16-bit parameter
//   registers. READ responses are queued as 4-word frames in a response FIFO
//   drained by usb_controller.
//   usb_clk, rst_n      : clock / synchronous active-low reset
//   receive_data(_en)   : incoming command word and its valid strobe
//   fifo_parameter_en   : response pop; parameter_data valid the next cycle
//   send_out            : 1-cycle pulse after a full response frame is queued
//   reg_bus             : flat register bank, reg i at [16*i +: 16]
//   reg_wr, reg_wr_addr : update pulse and address (ADDR_ALL for restore)
//   err_cnt             : saturating count of rejected / timed-out frames
module usb_cmd_decoder
    import usb_cmd_pkg::*;
#(
    parameter int               NREG    = 16,
    parameter logic [NREG*16-1:0] RST_VAL = '0,
    parameter int               TIMEOUT = 1024,
    parameter logic [15:0]      SYNC    = usb_cmd_pkg::SYNC
)(
    input  logic               usb_clk,
    input  logic               rst_n,
    input  logic [15:0]        receive_data,
    input  logic               receive_data_en,
    input  logic               fifo_parameter_en,
    output logic [15:0]        parameter_data,
    output logic               send_out,
    output logic [NREG*16-1:0] reg_bus,
    output logic               reg_wr,
    output logic [7:0]         reg_wr_addr,
    output logic [15:0]        err_cnt
);

    localparam int         AW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int         GW     = $clog2(TIMEOUT + 1);
    localparam logic [8:0] NREG_W = 9'(NREG);

    state_t                  state, state_nxt;
    exec_op_t                exec_op;

    logic [15:0]             hdr_q;      // {cmd, addr}
    logic [15:0]             dat_q;
    logic [15:0]             chk_q;
    logic [GW-1:0]           gap;
    logic [1:0]              push_idx;
    logic [15:0]             rsp_dat;    // register value snapshotted for READ
    logic [NREG-1:0][15:0]   regs;

    logic [7:0]              cmd;
    logic [7:0]              addr;
    logic                    chk_ok;
    logic                    addr_ok;
    logic                    fifo_room;
    logic                    in_frame;
    logic                    timeout;
    logic                    err_evt;
    logic [15:0]             rd_val;

    logic                    fifo_push;
    logic [15:0]             fifo_wdata;
    logic [RESP_CW-1:0]      fifo_cnt;

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    assign cmd       = hdr_q[15:8];
    assign addr      = hdr_q[7:0];
    assign chk_ok    = (frame_chk(hdr_q, dat_q) == chk_q);
    assign addr_ok   = ({1'b0, addr} < NREG_W);
    // Response space is checked at EXEC; pops during the push burst only add room.
    assign fifo_room = (fifo_cnt <= RESP_CW'(RESP_DEPTH - FRAME_LEN));
    assign rd_val    = regs[addr[AW-1:0]];

    assign in_frame  = (state == ST_HDR) || (state == ST_DAT) || (state == ST_CHK);
    // Gap counts idle cycles since the last accepted word; the abort happens on
    // the TIMEOUT-th consecutive idle cycle.
    assign timeout   = (gap == GW'(TIMEOUT - 1));

    // Checks in priority order: checksum, opcode, address, then FIFO space.
    always_comb begin
        exec_op = OP_ERR;
        if (chk_ok) begin
            case (cmd)
                CMD_WRITE:   exec_op = addr_ok ? OP_WRITE : OP_ERR;
                CMD_READ:    exec_op = (addr_ok && fifo_room) ? OP_READ : OP_ERR;
                CMD_RESTORE: exec_op = OP_RESTORE;
                default:     exec_op = OP_ERR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        err_evt    = 1'b0;
        fifo_push  = 1'b0;
        fifo_wdata = SYNC;
        case (state)
            ST_IDLE: begin
                if (receive_data_en && (receive_data == SYNC)) begin
                    state_nxt = ST_HDR;
                end
            end
            // Inside a frame every word is payload, including SYNC.
            ST_HDR, ST_DAT, ST_CHK: begin
                if (receive_data_en) begin
                    case (state)
                        ST_HDR:  state_nxt = ST_DAT;
                        ST_DAT:  state_nxt = ST_CHK;
                        default: state_nxt = ST_EXEC;
                    endcase
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                    err_evt   = 1'b1;
                end
            end
            ST_EXEC: begin
                err_evt   = (exec_op == OP_ERR);
                state_nxt = (exec_op == OP_READ) ? ST_PUSH : ST_IDLE;
            end
            ST_PUSH: begin
                fifo_push = 1'b1;
                case (push_idx)
                    2'd0:    fifo_wdata = SYNC;
                    2'd1:    fifo_wdata = hdr_q;
                    2'd2:    fifo_wdata = rsp_dat;
                    default: fifo_wdata = frame_chk(hdr_q, rsp_dat);
                endcase
                if (push_idx == 2'(FRAME_LEN - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame capture, gap counter, push sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (!rst_n) begin
            hdr_q    <= '0;
            dat_q    <= '0;
            chk_q    <= '0;
            gap      <= '0;
            push_idx <= '0;
            rsp_dat  <= '0;
            send_out <= 1'b0;
        end else begin
            if (in_frame && !receive_data_en) begin
                gap <= gap + GW'(1);
            end else begin
                gap <= '0;
            end

            if (receive_data_en) begin
                case (state)
                    ST_HDR:  hdr_q <= receive_data;
                    ST_DAT:  dat_q <= receive_data;
                    ST_CHK:  chk_q <= receive_data;
                    default: ;
                endcase
            end

            if (state == ST_EXEC) begin
                rsp_dat <= rd_val;
            end

            push_idx <= (state == ST_PUSH) ? push_idx + 2'd1 : 2'd0;
            send_out <= (state == ST_PUSH) && (push_idx == 2'(FRAME_LEN - 1));
        end
    end

    // ------------------------------------------------------------------
    // Register bank and error counter
    // ------------------------------------------------------------------
    always_ff @(posedge usb_clk) begin
        if (!rst_n) begin
            regs        <= RST_VAL;
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            err_cnt     <= '0;
        end else begin
            reg_wr <= 1'b0;
            if (state == ST_EXEC) begin
                case (exec_op)
                    OP_WRITE: begin
                        regs[addr[AW-1:0]] <= dat_q;
                        reg_wr             <= 1'b1;
                        reg_wr_addr        <= addr;
                    end
                    OP_RESTORE: begin
                        regs        <= RST_VAL;
                        reg_wr      <= 1'b1;
                        reg_wr_addr <= ADDR_ALL;
                    end
                    default: ;
                endcase
            end
            if (err_evt && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign reg_bus = regs;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    usb_resp_fifo u_resp_fifo (
        .clk   (usb_clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_parameter_en),
        .rdata (parameter_data),
        .count (fifo_cnt)
    );

endmodule
